// File: rtl/regfile_32x32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_32x32_pkg
// Purpose  : Shared sizing constants for the MIPS general-purpose register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_32x32_pkg;

    localparam int              REG_ADDR_W = 5;
    localparam int              REG_DATA_W = 32;
    localparam int              REG_DEPTH  = 1 << REG_ADDR_W;
    localparam logic [4:0]      REG_ZERO   = 5'd0;

endpackage : regfile_32x32_pkg
`default_nettype wire

// File: rtl/regfile_32x32_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_32x32_if
// Purpose  : Write-back and decode-side bus of the register file.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_32x32_if
    import regfile_32x32_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
);

    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [DATA_W-1:0] rd1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd2;
    logic [ADDR_W-1:0] dbg_ra;
    logic [DATA_W-1:0] dbg_rd;

    modport master (
        output we, wa, wd, ra1, ra2, dbg_ra,
        input  rd1, rd2, dbg_rd
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, dbg_ra,
        output rd1, rd2, dbg_rd
    );

endinterface : regfile_32x32_if
`default_nettype wire

// File: rtl/regfile_32x32_decoder5to32.sv
`default_nettype none
// ============================================================================
// Module   : decoder5to32
// Purpose  : Write-address decoder, we + wa -> one-hot register enable.
// Revision : 1.0 - initial release
// ============================================================================
module decoder5to32
    import regfile_32x32_pkg::*;
(
    input  wire logic                  we,
    input  wire logic [REG_ADDR_W-1:0] wa,
    output logic      [REG_DEPTH-1:0]  wen
);

    always_comb begin
        wen = '0;
        if (we) begin
            wen[wa] = 1'b1;
        end
        // r0 is hardwired zero, so its enable never fires
        wen[REG_ZERO] = 1'b0;
    end

endmodule : decoder5to32
`default_nettype wire

// File: rtl/regfile_32x32.sv
`default_nettype none
// ============================================================================
// Module   : regfile_32x32
// Purpose  : 32 x 32 MIPS register file, one sync write, two async reads plus
//            a debug read. Define REGFILE_BYPASS_EN for write-through reads.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_32x32
    import regfile_32x32_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
)(
    input  wire logic       clk,
    input  wire logic       rst_n,
    regfile_32x32_if.slave  bus
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [c_DEPTH-1:0] w_wen;
    logic [DATA_W-1:0]  w_regs [c_DEPTH];
    logic               w_unused;
    logic               w_byp1;
    logic               w_byp2;
    logic               w_bypd;

    decoder5to32 u_decoder (
        .we  (bus.we),
        .wa  (bus.wa),
        .wen (w_wen)
    );

    assign w_unused = w_wen[0];

    generate
        for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign w_regs[gi] = '0;
            end else begin : g_store
                logic [DATA_W-1:0] r_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_q <= '0;
                    end else if (w_wen[gi]) begin
                        r_q <= bus.wd;
                    end
                end
                assign w_regs[gi] = r_q;
            end
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    // Gated by rst_n so reads stay zero while reset is held
    assign w_byp1 = rst_n && bus.we && (bus.wa != '0) && (bus.ra1 == bus.wa);
    assign w_byp2 = rst_n && bus.we && (bus.wa != '0) && (bus.ra2 == bus.wa);
    assign w_bypd = rst_n && bus.we && (bus.wa != '0) && (bus.dbg_ra == bus.wa);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
    assign w_bypd = 1'b0;
`endif

    assign bus.rd1    = (bus.ra1 == '0)    ? '0 : (w_byp1 ? bus.wd : w_regs[bus.ra1]);
    assign bus.rd2    = (bus.ra2 == '0)    ? '0 : (w_byp2 ? bus.wd : w_regs[bus.ra2]);
    assign bus.dbg_rd = (bus.dbg_ra == '0) ? '0 : (w_bypd ? bus.wd : w_regs[bus.dbg_ra]);

endmodule : regfile_32x32
`default_nettype wire

// File: tb/tb_regfile_32x32.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_32x32
// Purpose  : Self-checking bench for regfile_32x32 against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_32x32;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] mem [32];

    regfile_32x32_if bus ();

    regfile_32x32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read value derived from the architectural rules
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (bus.we && bus.wa != 5'd0 && bus.wa == a) return bus.wd;
`endif
        return mem[a];
    endfunction

    task automatic check_ports(input string tag);
        check({tag, "_rd1"}, bus.rd1, exp_rd(bus.ra1));
        check({tag, "_rd2"}, bus.rd2, exp_rd(bus.ra2));
        check({tag, "_dbg"}, bus.dbg_rd, exp_rd(bus.dbg_ra));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && bus.we && bus.wa != 5'd0) mem[bus.wa] = bus.wd;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we = 1'b1; bus.wa = a; bus.wd = d;
        tick();
        bus.we = 1'b0;
    endtask

    function automatic logic [31:0] sweep_val(input int k);
        return k * 32'h01010101;
    endfunction

    initial begin
        clear_model();
        rst_n = 1'b0;
        bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
        bus.ra1 = 5'd1; bus.ra2 = 5'd31; bus.dbg_ra = 5'd16;
        #1;
        check_ports("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_ports("after_reset");

        // Async reset mid-cycle, observed before the next clock edge
        wr(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        bus.ra1 = 5'd5;
        #1;
        check("r5_written", bus.rd1, 32'hDEADBEEF);
        #1 rst_n = 1'b0;
        clear_model();
        #1;
        check("async_reset_rd1", bus.rd1, 32'h0);

        // Write attempted while reset held must be lost
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'hCAFEF00D;
        tick();
        @(negedge clk);
        bus.we = 1'b0;
        rst_n = 1'b1;
        bus.ra1 = 5'd7; bus.ra2 = 5'd5;
        #1;
        check("reset_wins_r7", bus.rd1, 32'h0);
        check("reset_cleared_r5", bus.rd2, 32'h0);

        wr(5'd8, 32'h12345678);
        @(negedge clk);
        bus.ra1 = 5'd8; bus.ra2 = 5'd8;
        #1;
        check("wr8_rd1", bus.rd1, 32'h12345678);
        check("wr8_rd2", bus.rd2, 32'h12345678);

        wr(5'd0, 32'hFFFFFFFF);
        @(negedge clk);
        bus.ra1 = 5'd0; bus.ra2 = 5'd0; bus.dbg_ra = 5'd0;
        #1;
        check("zero_rd1", bus.rd1, 32'h0);
        check("zero_rd2", bus.rd2, 32'h0);
        check("zero_dbg", bus.dbg_rd, 32'h0);
        for (int i = 1; i < 32; i++) begin
            bus.dbg_ra = 5'(i);
            #1;
            check($sformatf("unchanged_r%0d", i), bus.dbg_rd, (i == 8) ? 32'h12345678 : 32'h0);
        end

        @(negedge clk);
        bus.we = 1'b0; bus.wa = 5'd3; bus.wd = 32'hA5A5A5A5;
        tick();
        bus.ra1 = 5'd3;
        #1;
        check("we0_r3", bus.rd1, 32'h0);

        // Same-cycle read/write hazard on r9
        wr(5'd9, 32'h11);
        @(negedge clk);
        bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h22; bus.ra1 = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("hazard_pre_edge", bus.rd1, 32'h22);
`else
        check("hazard_pre_edge", bus.rd1, 32'h11);
`endif
        tick();
        check("hazard_post_edge", bus.rd1, 32'h22);
        bus.we = 1'b0;
        #1;
        check("hazard_settled", bus.rd1, 32'h22);

        for (int i = 1; i < 32; i++) wr(5'(i), sweep_val(i));
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            bus.ra1 = 5'(i); bus.ra2 = 5'(31 - i); bus.dbg_ra = 5'((i + 7) % 32);
            #1;
            check($sformatf("sweep_rd1_%0d", i), bus.rd1, sweep_val(i));
            check($sformatf("sweep_rd2_%0d", i), bus.rd2, sweep_val(31 - i));
            check($sformatf("sweep_dbg_%0d", i), bus.dbg_rd, sweep_val((i + 7) % 32));
        end

        // Randomized traffic against the array model
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            bus.we  = 1'($urandom_range(0, 1));
            bus.wa  = 5'($urandom_range(0, 31));
            bus.wd  = $urandom;
            bus.ra1 = ($urandom_range(0, 3) == 0) ? bus.wa : 5'($urandom_range(0, 31));
            bus.ra2 = ($urandom_range(0, 3) == 0) ? bus.wa : 5'($urandom_range(0, 31));
            bus.dbg_ra = ($urandom_range(0, 3) == 0) ? bus.wa : 5'($urandom_range(0, 31));
            #1;
            check_ports($sformatf("rand%0d", n));
            tick();
        end
        bus.we = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_32x32
`default_nettype wire
